// File: rtl/div_pkg.sv
// Shared divider definitions: operand widths, BCD conversion constants and
// the result-stage FSM encoding.
package div_pkg;

  localparam int unsigned DIV_Q_W     = 6;
  localparam int unsigned DIV_R_W     = 4;
  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned CONV_CYCLES = 6;
  localparam int unsigned OP_W        = 6;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StConv = 2'd1,
    StHold = 2'd2
  } conv_state_e;

endpackage

// File: rtl/bcd_nibble_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more
// so the following left shift carries correctly into the next digit.
module bcd_nibble_adj
  import div_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] nibble,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  always_comb begin
    adjusted = nibble;
    if (nibble >= BCD_DIGIT_W'(5)) begin
      adjusted = nibble + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/div_result_bcd.sv
// Captures the divider quotient/remainder on the rising edge of done and
// converts both to two-digit packed BCD with a sequential double-dabble engine.
module div_result_bcd
  import div_pkg::*;
#(
  parameter int unsigned Q_W = DIV_Q_W,
  parameter int unsigned R_W = DIV_R_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           done,
  input  logic [Q_W-1:0] Q,
  input  logic [R_W-1:0] R,
  output logic [7:0]     bcd_q,
  output logic [7:0]     bcd_r,
  output logic           valid,
  output logic           busy,
  output logic           overrun
);

  conv_state_e     state_q, state_d;
  logic            done_d;
  logic [2:0]      cnt_q;
  logic [OP_W-1:0] qop_q, rop_q;
  logic [7:0]      qs_q, rs_q;
  logic [7:0]      qs_next, rs_next;
  logic [3:0]      q_lo_adj, q_hi_adj, r_lo_adj, r_hi_adj;
  logic            capture, last;

  assign capture = done & ~done_d;
  assign last    = (state_q == StConv) && (cnt_q == 3'(CONV_CYCLES - 1));

  bcd_nibble_adj u_adj_q_lo (.nibble(qs_q[3:0]), .adjusted(q_lo_adj));
  bcd_nibble_adj u_adj_q_hi (.nibble(qs_q[7:4]), .adjusted(q_hi_adj));
  bcd_nibble_adj u_adj_r_lo (.nibble(rs_q[3:0]), .adjusted(r_lo_adj));
  bcd_nibble_adj u_adj_r_hi (.nibble(rs_q[7:4]), .adjusted(r_hi_adj));

  // Tens digit stays below 8, so the top bit of the corrected tens nibble drops.
  assign qs_next = 8'({q_hi_adj, q_lo_adj, qop_q[OP_W-1]});
  assign rs_next = 8'({r_hi_adj, r_lo_adj, rop_q[OP_W-1]});

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StHold: if (capture) state_d = StConv;
      StConv:         if (last) state_d = StHold;
      default:        state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      done_d  <= 1'b1;  // a done already high at reset release is not an edge
      cnt_q   <= '0;
      qop_q   <= '0;
      rop_q   <= '0;
      qs_q    <= '0;
      rs_q    <= '0;
      bcd_q   <= '0;
      bcd_r   <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      done_d  <= done;
      if (state_q == StConv) begin
        qs_q  <= qs_next;
        rs_q  <= rs_next;
        qop_q <= {qop_q[OP_W-2:0], 1'b0};
        rop_q <= {rop_q[OP_W-2:0], 1'b0};
        cnt_q <= cnt_q + 3'd1;
        if (last) begin
          bcd_q <= qs_next;
          bcd_r <= rs_next;
          valid <= 1'b1;
          busy  <= 1'b0;
        end
        if (capture) begin
          overrun <= 1'b1;
        end
      end else if (capture) begin
        qop_q <= OP_W'(Q);
        rop_q <= OP_W'(R);
        qs_q  <= '0;
        rs_q  <= '0;
        cnt_q <= '0;
        valid <= 1'b0;
        busy  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_result_bcd.sv
// Randomised bench for div_result_bcd against a decimal-arithmetic model.
module tb_div_result_bcd;

  logic       clk = 1'b0;
  logic       reset;
  logic       done;
  logic [5:0] Q;
  logic [3:0] R;
  logic [7:0] bcd_q, bcd_r;
  logic       valid, busy, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_result_bcd dut (
    .clk    (clk),
    .reset  (reset),
    .done   (done),
    .Q      (Q),
    .R      (R),
    .bcd_q  (bcd_q),
    .bcd_r  (bcd_r),
    .valid  (valid),
    .busy   (busy),
    .overrun(overrun)
  );

  function automatic logic [7:0] to_bcd(input logic [5:0] x);
    int unsigned v;
    v = {26'd0, x};
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion; Q/R are scrambled after capture to prove they were latched.
  task automatic run_conv(input logic [5:0] q, input logic [3:0] r, input string tag);
    logic [7:0] eq, er;
    eq = to_bcd(q);
    er = to_bcd({2'b00, r});
    done = 1'b0;
    tick();
    Q = q;
    R = r;
    done = 1'b1;
    tick();
    check_eq({tag, ".busy_e0"}, 8'(busy), 8'd1);
    check_eq({tag, ".valid_e0"}, 8'(valid), 8'd0);
    for (int i = 1; i <= 5; i++) begin
      Q = 6'($urandom);
      R = 4'($urandom);
      tick();
    end
    check_eq({tag, ".busy_e5"}, 8'(busy), 8'd1);
    check_eq({tag, ".valid_e5"}, 8'(valid), 8'd0);
    tick();
    check_eq({tag, ".valid_e6"}, 8'(valid), 8'd1);
    check_eq({tag, ".busy_e6"}, 8'(busy), 8'd0);
    check_eq({tag, ".bcd_q"}, bcd_q, eq);
    check_eq({tag, ".bcd_r"}, bcd_r, er);
    done = 1'b0;
  endtask

  initial begin
    int         busy_cnt;
    int         busy_rises;
    logic       busy_prev;
    logic [5:0] q0;
    logic [3:0] r0;

    reset = 1'b1;
    done  = 1'b1;
    Q     = '0;
    R     = '0;
    tick();
    tick();
    check_eq("rst.bcd_q", bcd_q, 8'h00);
    check_eq("rst.bcd_r", bcd_r, 8'h00);
    check_eq("rst.valid", 8'(valid), 8'd0);
    check_eq("rst.busy", 8'(busy), 8'd0);
    check_eq("rst.overrun", 8'(overrun), 8'd0);

    // done already high at reset release must not start a conversion
    reset = 1'b0;
    repeat (3) tick();
    check_eq("held.busy", 8'(busy), 8'd0);
    check_eq("held.valid", 8'(valid), 8'd0);

    run_conv(6'd42, 4'd3, "q42");
    run_conv(6'd63, 4'd15, "max");
    run_conv(6'd0, 4'd0, "zero");
    for (int i = 0; i < 12; i++) begin
      run_conv(6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)), "rand");
    end

    // Second rising edge during CONV is dropped and flagged
    done = 1'b0;
    tick();
    Q = 6'd17;
    R = 4'd9;
    done = 1'b1;
    tick();
    repeat (3) tick();
    done = 1'b0;
    tick();
    Q = 6'd5;
    R = 4'd1;
    done = 1'b1;
    tick();
    check_eq("ovr.flag_e5", 8'(overrun), 8'd1);
    check_eq("ovr.busy_e5", 8'(busy), 8'd1);
    tick();
    check_eq("ovr.valid", 8'(valid), 8'd1);
    check_eq("ovr.bcd_q", bcd_q, to_bcd(6'd17));
    check_eq("ovr.bcd_r", bcd_r, to_bcd(6'd9));
    done = 1'b0;
    repeat (3) tick();
    check_eq("ovr.sticky", 8'(overrun), 8'd1);
    check_eq("ovr.hold_q", bcd_q, to_bcd(6'd17));

    // Reset in the middle of a conversion
    done = 1'b0;
    tick();
    Q = 6'd51;
    R = 4'd7;
    done = 1'b1;
    tick();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_eq("rmid.bcd_q", bcd_q, 8'h00);
    check_eq("rmid.bcd_r", bcd_r, 8'h00);
    check_eq("rmid.valid", 8'(valid), 8'd0);
    check_eq("rmid.busy", 8'(busy), 8'd0);
    check_eq("rmid.overrun", 8'(overrun), 8'd0);
    reset = 1'b0;
    repeat (2) tick();
    check_eq("rmid.nocap", 8'(busy), 8'd0);
    run_conv(6'd8, 4'd2, "post_rst");

    // done held high: exactly one 6-cycle busy pulse, result from capture-time Q/R
    q0 = 6'($urandom);
    r0 = 4'($urandom);
    done = 1'b0;
    tick();
    Q = q0;
    R = r0;
    done = 1'b1;
    busy_prev  = busy;
    busy_cnt   = 0;
    busy_rises = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy) busy_cnt++;
      if (busy && !busy_prev) busy_rises++;
      busy_prev = busy;
      Q = 6'($urandom);
      R = 4'($urandom);
    end
    check_eq("long.busy_cycles", 8'(busy_cnt), 8'd6);
    check_eq("long.busy_pulses", 8'(busy_rises), 8'd1);
    check_eq("long.valid", 8'(valid), 8'd1);
    check_eq("long.bcd_q", bcd_q, to_bcd(q0));
    check_eq("long.bcd_r", bcd_r, to_bcd({2'b00, r0}));
    done = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
